xpb_chunk_accum: RTL and testbench

//   Sequential reduction accumulator downstream of the xpb_5_* lookup tables.
//   - Takes the low WORD_BITS of a squared product plus NUM_CHUNKS 5-bit slices of its upper part.
//   - Steps through the slices one per cycle and drives the slice onto the shared xpb LUT bank.
//   - Adds each returned precomputed multiple into a wide accumulator.
//   - Emits the partially reduced sum to the next modular-square stage.

---
 rtl/xpb_pkg.sv | 24 ++
 rtl/xpb_chunk_accum.sv | 93 +++++++++
 tb/tb_xpb_chunk_accum.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/xpb_pkg.sv
// Shared types and sizes for the xpb reduction path: accumulator widths,
// the accumulator FSM encoding and the helper that extracts one upper-product slice.
package xpb_pkg;

  localparam int WORD_BITS  = 1024;
  localparam int CHUNK_BITS = 5;
  localparam int NUM_CHUNKS = 8;
  localparam int ACC_BITS   = WORD_BITS + $clog2(NUM_CHUNKS + 1);
  localparam int K_BITS     = $clog2(NUM_CHUNKS);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  function automatic logic [CHUNK_BITS-1:0] slice_of(
    input logic [NUM_CHUNKS*CHUNK_BITS-1:0] chunks,
    input logic [K_BITS-1:0]                k
  );
    return chunks[int'(k)*CHUNK_BITS +: CHUNK_BITS];
  endfunction

endpackage

// File: rtl/xpb_chunk_accum.sv
// Sequential xpb reduction: seeds a wide accumulator with the low product word,
// then adds one LUT-supplied multiple per upper slice and hands the sum downstream.
module xpb_chunk_accum
  import xpb_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_BITS-1:0]             in_low,
  input  logic [NUM_CHUNKS*CHUNK_BITS-1:0] in_chunks,
  output logic [K_BITS-1:0]                lut_chunk,
  output logic [CHUNK_BITS-1:0]            lut_sel,
  input  logic [WORD_BITS-1:0]             lut_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_BITS-1:0]              out_sum
);

  state_t                          state_q, state_d;
  logic [ACC_BITS-1:0]             acc_q, acc_d;
  logic [NUM_CHUNKS*CHUNK_BITS-1:0] chunks_q, chunks_d;
  logic [K_BITS-1:0]               k_q, k_d;
  logic [CHUNK_BITS-1:0]           sel_q, sel_d;
  logic                            out_valid_q, out_valid_d;

  // lut_chunk/lut_sel are preloaded on the accept edge so the first ACCUM
  // cycle already sees slice 0's table entry on lut_data.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    chunks_d    = chunks_q;
    k_d         = k_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d    = ACC_BITS'(in_low);
          chunks_d = in_chunks;
          k_d      = '0;
          sel_d    = slice_of(in_chunks, '0);
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + ACC_BITS'(lut_data);
        if (k_q == K_BITS'(NUM_CHUNKS - 1)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          k_d   = K_BITS'(k_q + 1'b1);
          sel_d = slice_of(chunks_q, K_BITS'(k_q + 1'b1));
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    chunks_q <= chunks_d;
  end

  // Gated by reset so the block never advertises readiness while being reset.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign lut_chunk = k_q;
  assign lut_sel   = sel_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;

endmodule

// File: tb/tb_xpb_chunk_accum.sv
// Bench for xpb_chunk_accum: stub and random-table LUTs, directed corner cases
// and randomized operations compared against a plain-arithmetic reference sum.
module tb_xpb_chunk_accum;
  import xpb_pkg::*;

  localparam int NC = NUM_CHUNKS;

  logic                             clk = 1'b0;
  logic                             reset;
  logic                             in_valid;
  logic                             in_ready;
  logic [WORD_BITS-1:0]             in_low;
  logic [NUM_CHUNKS*CHUNK_BITS-1:0] in_chunks;
  logic [K_BITS-1:0]                lut_chunk;
  logic [CHUNK_BITS-1:0]            lut_sel;
  logic [WORD_BITS-1:0]             lut_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [ACC_BITS-1:0]              out_sum;

  int checks = 0;
  int errors = 0;

  logic             use_tab = 1'b0;
  logic [WORD_BITS-1:0] tab [NC][32];

  always #5 clk = ~clk;

  xpb_chunk_accum dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_low    (in_low),
    .in_chunks (in_chunks),
    .lut_chunk (lut_chunk),
    .lut_sel   (lut_sel),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  always_comb begin
    lut_data = '0;
    if (use_tab) lut_data = tab[lut_chunk][lut_sel];
    else         lut_data = WORD_BITS'((32'(lut_chunk) + 32'd1) * 32'(lut_sel));
  end

  task automatic chk_eq(input string tag, input logic [ACC_BITS-1:0] got,
                        input logic [ACC_BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got hi=%0h lo=%032h want hi=%0h lo=%032h", tag,
               got[ACC_BITS-1:WORD_BITS], got[127:0],
               exp[ACC_BITS-1:WORD_BITS], exp[127:0]);
    end
  endtask

  function automatic logic [ACC_BITS-1:0] ref_sum(input logic [WORD_BITS-1:0] low,
                                                  input logic [NUM_CHUNKS*CHUNK_BITS-1:0] ch);
    logic [ACC_BITS-1:0] s;
    logic [NUM_CHUNKS*CHUNK_BITS-1:0] rest;
    int sel;
    s    = ACC_BITS'(low);
    rest = ch;
    for (int k = 0; k < NC; k++) begin
      sel  = int'(rest % 32);
      rest = rest / 32;
      if (use_tab) s = s + ACC_BITS'(tab[k][sel]);
      else         s = s + ACC_BITS'((k + 1) * sel);
    end
    return s;
  endfunction

  function automatic logic [WORD_BITS-1:0] rand_word();
    logic [WORD_BITS-1:0] w;
    for (int i = 0; i < WORD_BITS / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [NUM_CHUNKS*CHUNK_BITS-1:0] all_slices(input int v);
    logic [NUM_CHUNKS*CHUNK_BITS-1:0] c;
    c = '0;
    for (int k = 0; k < NC; k++) c = c * 32 + (NUM_CHUNKS*CHUNK_BITS)'(v);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers an operand in IDLE; returns after the accept edge.
  task automatic offer(input logic [WORD_BITS-1:0] low,
                       input logic [NUM_CHUNKS*CHUNK_BITS-1:0] ch);
    int n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    chk_eq("offer_ready", ACC_BITS'(in_ready), ACC_BITS'(1));
    in_valid  = 1'b1;
    in_low    = low;
    in_chunks = ch;
    tick();
    in_valid  = 1'b0;
  endtask

  // Waits for out_valid; optionally scrambles inputs meanwhile. Returns edges waited.
  task automatic wait_result(input bit scramble, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      if (scramble) begin
        in_low    = rand_word();
        in_chunks = {8'($urandom), $urandom};
        in_valid  = 1'($urandom);
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [WORD_BITS-1:0] low,
                        input logic [NUM_CHUNKS*CHUNK_BITS-1:0] ch, input bit scramble);
    logic [ACC_BITS-1:0] exp;
    int n;
    exp = ref_sum(low, ch);
    offer(low, ch);
    wait_result(scramble, n);
    chk_eq({tag, "_lat"}, ACC_BITS'(n), ACC_BITS'(NC));
    chk_eq({tag, "_sum"}, out_sum, exp);
    tick();
    chk_eq({tag, "_idle"}, ACC_BITS'({in_ready, out_valid}), ACC_BITS'(2'b10));
  endtask

  initial begin
    logic [ACC_BITS-1:0] exp1, exp2, carry_exp;
    logic [NUM_CHUNKS*CHUNK_BITS-1:0] c2;
    logic [WORD_BITS-1:0] l2;
    int n;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_low = '0; in_chunks = '0;
    tick(); tick();
    chk_eq("rst_in_ready", ACC_BITS'(in_ready), '0);
    chk_eq("rst_out_valid", ACC_BITS'(out_valid), '0);
    chk_eq("rst_out_sum", out_sum, '0);
    chk_eq("rst_lut", ACC_BITS'({lut_chunk, lut_sel}), '0);
    reset = 1'b0;
    #1;
    chk_eq("post_rst_ready", ACC_BITS'(in_ready), ACC_BITS'(1));

    // Directed cases with the stub LUT
    run_op("zeros", WORD_BITS'(16'h1234), '0, 1'b0);
    chk_eq("zeros_model", ref_sum(WORD_BITS'(16'h1234), '0), ACC_BITS'(16'h1234));
    run_op("ones", '0, all_slices(1), 1'b0);
    chk_eq("ones_value", ref_sum('0, all_slices(1)), ACC_BITS'(36));
    carry_exp = '0;
    carry_exp[WORD_BITS] = 1'b1;
    run_op("carry", '1, (NUM_CHUNKS*CHUNK_BITS)'(1), 1'b0);
    chk_eq("carry_value", out_sum, carry_exp);

    // Back-pressure with a second operand offered throughout DONE
    out_ready = 1'b0;
    exp1 = ref_sum(WORD_BITS'(77), all_slices(5));
    l2 = WORD_BITS'(1000);
    c2 = all_slices(3);
    exp2 = ref_sum(l2, c2);
    offer(WORD_BITS'(77), all_slices(5));
    wait_result(1'b0, n);
    chk_eq("bp_lat", ACC_BITS'(n), ACC_BITS'(NC));
    in_valid = 1'b1; in_low = l2; in_chunks = c2;
    for (int i = 0; i < 20; i++) begin
      chk_eq("bp_sum", out_sum, exp1);
      chk_eq("bp_flags", ACC_BITS'({out_valid, in_ready}), ACC_BITS'(2'b10));
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk_eq("bp_release", ACC_BITS'({out_valid, in_ready}), ACC_BITS'(2'b01));
    tick();
    in_valid = 1'b0;
    wait_result(1'b0, n);
    chk_eq("bp_second_lat", ACC_BITS'(n), ACC_BITS'(NC));
    chk_eq("bp_second_sum", out_sum, exp2);
    tick();

    // Reset while accumulating at k=3
    offer(WORD_BITS'(55), all_slices(7));
    tick(); tick(); tick();
    chk_eq("mid_k", ACC_BITS'(lut_chunk), ACC_BITS'(3));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_eq("mid_rst_flags", ACC_BITS'({out_valid, in_ready}), ACC_BITS'(2'b01));
    chk_eq("mid_rst_sum", out_sum, '0);
    for (int i = 0; i < NC + 2; i++) begin
      if (out_valid) chk_eq("mid_rst_emit", ACC_BITS'(out_valid), '0);
      tick();
    end
    run_op("twos", '0, all_slices(2), 1'b0);
    chk_eq("twos_value", ref_sum('0, all_slices(2)), ACC_BITS'(72));

    // Random table LUT, random operands, inputs scrambled after acceptance
    for (int k = 0; k < NC; k++)
      for (int s = 0; s < 32; s++)
        tab[k][s] = (s == 0) ? '0 : rand_word();
    use_tab = 1'b1;
    for (int i = 0; i < 1000; i++)
      run_op("rand", rand_word(), {8'($urandom), $urandom}, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
